// File: rtl/reg_file_3p_pkg.sv
// Shared register-file types and constants for decode, forwarding and WB.
// Optional write-before-read bypass: define REGFILE_BYPASS_EN.
package reg_file_3p_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int WCNT_W   = 16;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] ridx_t;
    typedef logic [WCNT_W-1:0] wcnt_t;
    typedef word_t [NUM_REGS-1:0] regs_t;

    localparam ridx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_file_3p_if.sv
// Decode/writeback bus of the register file.
// master = pipeline side, slave = register file.
interface reg_file_3p_if;
    import reg_file_3p_pkg::*;

    ridx_t rd_addr_a;
    ridx_t rd_addr_b;
    word_t rd_data_a;
    word_t rd_data_b;
    logic  wr_en;
    ridx_t wr_addr;
    word_t wr_data;
    ridx_t dbg_addr;
    word_t dbg_data;
    wcnt_t wr_count;

    modport master (
        output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, dbg_addr,
        input  rd_data_a, rd_data_b, dbg_data, wr_count
    );

    modport slave (
        input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, dbg_addr,
        output rd_data_a, rd_data_b, dbg_data, wr_count
    );

endinterface

// File: rtl/reg_read_port.sv
// One combinational read port: array mux, $zero check, optional bypass.
// byp_en_i=0 gives a plain array read.
module reg_read_port
    import reg_file_3p_pkg::*;
(
    input  regs_t regs_i,
    input  ridx_t addr_i,
    input  logic  byp_en_i,
    input  logic  wr_en_i,
    input  ridx_t wr_addr_i,
    input  word_t wr_data_i,
    output word_t data_o
);

    logic hit;

    assign hit = byp_en_i && wr_en_i
              && (wr_addr_i != REG_ZERO)
              && (wr_addr_i == addr_i);

    always_comb begin
        data_o = regs_i[addr_i];
        if (addr_i == REG_ZERO) begin
            data_o = '0;
        end else if (hit) begin
            data_o = wr_data_i;
        end
    end

endmodule

// File: rtl/reg_file_3p.sv
// MIPS 32x32 register file: 2 read ports, 1 write port, 1 debug port.
// Define REGFILE_BYPASS_EN for same-cycle WB->ID write-before-read.
module reg_file_3p
    import reg_file_3p_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    reg_file_3p_if.slave  rf
);

    logic [NUM_REGS-1:1][DATA_W-1:0] regs_q;
    wcnt_t wr_count_q;
    wcnt_t wr_count_d;
    regs_t regs_rd;
    logic  do_wr;
    logic  byp_en;

    assign do_wr      = rf.wr_en && (rf.wr_addr != REG_ZERO);
    assign wr_count_d = wr_count_q + WCNT_W'(1);
    assign regs_rd    = {regs_q, word_t'(0)};

    // Bypass is masked in reset so every port reads 0 while rst_n is low.
`ifdef REGFILE_BYPASS_EN
    assign byp_en = rst_n;
`else
    assign byp_en = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q     <= '0;
            wr_count_q <= '0;
        end else if (do_wr) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (rf.wr_addr == ridx_t'(i)) begin
                    regs_q[i] <= rf.wr_data;
                end
            end
            wr_count_q <= wr_count_d;
        end
    end

    reg_read_port u_port_a (
        .regs_i    (regs_rd),
        .addr_i    (rf.rd_addr_a),
        .byp_en_i  (byp_en),
        .wr_en_i   (rf.wr_en),
        .wr_addr_i (rf.wr_addr),
        .wr_data_i (rf.wr_data),
        .data_o    (rf.rd_data_a)
    );

    reg_read_port u_port_b (
        .regs_i    (regs_rd),
        .addr_i    (rf.rd_addr_b),
        .byp_en_i  (byp_en),
        .wr_en_i   (rf.wr_en),
        .wr_addr_i (rf.wr_addr),
        .wr_data_i (rf.wr_data),
        .data_o    (rf.rd_data_b)
    );

    reg_read_port u_port_dbg (
        .regs_i    (regs_rd),
        .addr_i    (rf.dbg_addr),
        .byp_en_i  (1'b0),
        .wr_en_i   (rf.wr_en),
        .wr_addr_i (rf.wr_addr),
        .wr_data_i (rf.wr_data),
        .data_o    (rf.dbg_data)
    );

    assign rf.wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_file_3p.sv
// Bench for reg_file_3p: array model plus directed literal pins.
// Honours REGFILE_BYPASS_EN when the build defines it.
module tb_reg_file_3p;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    reg_file_3p_if rf();

    reg_file_3p dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rf)
    );

    always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl [32];
    int unsigned mcnt = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Architectural state: what has been committed since reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (mdl[i]) mdl[i] = 32'h0;
            mcnt = 0;
        end else if (rf.wr_en === 1'b1 && rf.wr_addr != 5'd0) begin
            mdl[rf.wr_addr] = rf.wr_data;
            mcnt = (mcnt + 1) % 65536;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] a,
                                           input bit port_byp);
        if (!rst_n || a == 5'd0) return 32'h0;
        if (port_byp && BYP && rf.wr_en === 1'b1 && rf.wr_addr == a)
            return rf.wr_data;
        return mdl[a];
    endfunction

    always @(negedge clk) begin
        check("rd_data_a", rf.rd_data_a, exp_rd(rf.rd_addr_a, 1'b1));
        check("rd_data_b", rf.rd_data_b, exp_rd(rf.rd_addr_b, 1'b1));
        check("dbg_data",  rf.dbg_data,  exp_rd(rf.dbg_addr, 1'b0));
        check("wr_count",  32'(rf.wr_count), rst_n ? mcnt : 32'h0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        rf.wr_en   = 1'b1;
        rf.wr_addr = a;
        rf.wr_data = d;
        step();
        rf.wr_en   = 1'b0;
    endtask

    initial begin
        rf.rd_addr_a = '0;
        rf.rd_addr_b = '0;
        rf.dbg_addr  = '0;
        rf.wr_en     = 1'b0;
        rf.wr_addr   = '0;
        rf.wr_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        @(negedge clk);
        check("lit_reset_count", 32'(rf.wr_count), 32'h0);
        check("lit_reset_r0", rf.rd_data_a, 32'h0);
        step();

        wr(5'd8, 32'hDEADBEEF);
        rf.rd_addr_b = 5'd8;
        rf.dbg_addr  = 5'd8;
        @(negedge clk);
        check("lit_r8_b", rf.rd_data_b, 32'hDEADBEEF);
        check("lit_r8_dbg", rf.dbg_data, 32'hDEADBEEF);
        check("lit_r8_count", 32'(rf.wr_count), 32'd1);
        step();

        wr(5'd0, 32'hFFFFFFFF);
        rf.rd_addr_a = 5'd0;
        @(negedge clk);
        check("lit_zero_a", rf.rd_data_a, 32'h0);
        check("lit_zero_count", 32'(rf.wr_count), 32'd1);
        step();

        wr(5'd9, 32'h11);
        rf.wr_en     = 1'b1;
        rf.wr_addr   = 5'd9;
        rf.wr_data   = 32'h22;
        rf.rd_addr_a = 5'd9;
        rf.dbg_addr  = 5'd9;
        @(negedge clk);
        check("lit_r9_pre_a", rf.rd_data_a, BYP ? 32'h22 : 32'h11);
        check("lit_r9_pre_dbg", rf.dbg_data, 32'h11);
        step();
        rf.wr_en = 1'b0;
        @(negedge clk);
        check("lit_r9_post_a", rf.rd_data_a, 32'h22);
        check("lit_r9_post_dbg", rf.dbg_data, 32'h22);
        check("lit_r9_count", 32'(rf.wr_count), 32'd3);
        step();

        wr(5'd3, 32'h33);
        rf.wr_addr   = 5'd3;
        rf.wr_data   = 'x;
        rf.rd_addr_a = 5'd3;
        repeat (10) step();
        @(negedge clk);
        check("lit_hold_r3", rf.rd_data_a, 32'h33);
        check("lit_hold_count", 32'(rf.wr_count), 32'd4);
        step();
        rf.wr_data = '0;

        wr(5'd5, 32'h1234);
        rf.rd_addr_a = 5'd5;
        #2;
        check("lit_r5_before", rf.rd_data_a, 32'h1234);
        rst_n = 1'b0;
        #1;
        check("lit_async_r5", rf.rd_data_a, 32'h0);
        check("lit_async_count", 32'(rf.wr_count), 32'h0);
        rf.wr_en     = 1'b1;
        rf.wr_addr   = 5'd7;
        rf.wr_data   = 32'hAA;
        rf.rd_addr_b = 5'd7;
        step();
        rf.wr_en = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        check("lit_rstwin_r7", rf.rd_data_b, 32'h0);
        check("lit_rstwin_count", 32'(rf.wr_count), 32'h0);
        step();

        for (int i = 0; i < 65536; i++) wr(5'd1, 32'(i));
        rf.rd_addr_a = 5'd1;
        @(negedge clk);
        check("lit_wrap_count", 32'(rf.wr_count), 32'h0);
        check("lit_wrap_r1", rf.rd_data_a, 32'h0000FFFF);
        step();

        repeat (3000) begin
            rf.rd_addr_a = 5'($urandom);
            rf.rd_addr_b = ($urandom_range(0, 3) == 0) ? rf.rd_addr_a
                                                       : 5'($urandom);
            rf.dbg_addr  = 5'($urandom);
            rf.wr_en     = ($urandom_range(0, 9) < 7);
            rf.wr_addr   = ($urandom_range(0, 2) == 0) ? rf.rd_addr_a
                                                       : 5'($urandom);
            rf.wr_data   = $urandom;
            rst_n        = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n    = 1'b1;
        rf.wr_en = 1'b0;
        @(negedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
